// File: rtl/vdp_arb_pkg.sv
// Shared constants, state encoding and helpers for the 8-way VDP request arbiter.
package vdp_arb_pkg;

    localparam int unsigned NUM_REQ           = 8;
    localparam int unsigned SEL_W             = 3;
    localparam int unsigned DEFAULT_MAX_BURST = 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    // 3-to-8 decode matching the datapath select decode.
    function automatic logic [NUM_REQ-1:0] sel_onehot(input logic [SEL_W-1:0] s);
        sel_onehot = NUM_REQ'(1) << s;
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin pick: first set request scanning ptr, ptr+1, ... (mod 8).
module rr_pick8
    import vdp_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic [SEL_W-1:0]   idx,
    output logic               found
);

    logic [NUM_REQ-1:0] rot;
    logic [SEL_W-1:0]   off;
    logic               hit;

    // Rotate so ptr lands at bit 0; 3-bit index arithmetic wraps mod 8.
    always_comb begin
        rot = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            rot[i] = req[SEL_W'(ptr + SEL_W'(i))];
        end
    end

    always_comb begin
        off = '0;
        hit = 1'b0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (rot[i] && !hit) begin
                off = SEL_W'(i);
                hit = 1'b1;
            end
        end
    end

    assign idx   = SEL_W'(ptr + off);
    assign found = |req;

endmodule

// File: rtl/vdp_req_arbiter8.sv
// Round-robin 8-way port arbiter with burst-length limit and a mandatory turnaround gap.
// Optional macro VDP_ARB_PRIO0_EN: requester 0 wins IDLE arbitration and is never preempted.
module vdp_req_arbiter8
    import vdp_arb_pkg::*;
#(
    parameter int unsigned MAX_BURST = DEFAULT_MAX_BURST
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [SEL_W-1:0]   sel,
    output logic [NUM_REQ-1:0] grant,
    output logic               gnt_valid,
    output logic               preempt
);

    localparam int unsigned       CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

    arb_state_e         state_q, state_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SEL_W-1:0]   sel_d;
    logic [NUM_REQ-1:0] grant_d;
    logic               valid_d;
    logic               preempt_d;

    logic [SEL_W-1:0]   pick_idx;
    logic               pick_found;
    logic [SEL_W-1:0]   win_idx_c;
    logic               exempt_c;
    logic               owner_req_c;
    logic               others_req_c;
    logic               burst_done_c;
    logic               release_c;
    logic               force_c;

    rr_pick8 u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

`ifdef VDP_ARB_PRIO0_EN
    // Display refresh fetch overrides the rotation and is immune to burst preemption.
    assign win_idx_c = req[0] ? '0 : pick_idx;
    assign exempt_c  = (sel == '0);
`else
    assign win_idx_c = pick_idx;
    assign exempt_c  = 1'b0;
`endif

    assign owner_req_c  = req[sel];
    assign others_req_c = |(req & ~sel_onehot(sel));
    assign burst_done_c = (cnt_q == CNT_MAX);
    assign release_c    = !owner_req_c;
    assign force_c      = burst_done_c && others_req_c && !exempt_c;

    // Next-state and registered-output values.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        sel_d     = sel;
        grant_d   = grant;
        valid_d   = gnt_valid;
        preempt_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                grant_d = '0;
                valid_d = 1'b0;
                if (pick_found) begin
                    state_d = ST_GRANT;
                    sel_d   = win_idx_c;
                    grant_d = sel_onehot(win_idx_c);
                    valid_d = 1'b1;
                    cnt_d   = CNT_ONE;
                end
            end

            ST_GRANT: begin
                if (!burst_done_c) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
                if (release_c || force_c) begin
                    // Voluntary release takes precedence, so preempt only on a forced end.
                    state_d   = ST_IDLE;
                    grant_d   = '0;
                    valid_d   = 1'b0;
                    cnt_d     = '0;
                    preempt_d = !release_c;
                    if (!exempt_c) begin
                        ptr_d = SEL_W'(sel + SEL_W'(1));
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            sel       <= '0;
            grant     <= '0;
            gnt_valid <= 1'b0;
            preempt   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            sel       <= sel_d;
            grant     <= grant_d;
            gnt_valid <= valid_d;
            preempt   <= preempt_d;
        end
    end

`ifndef SYNTHESIS
    a_grant_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
    a_grant_valid   : assert property (@(posedge clk) disable iff (rst) ((grant != '0) == gnt_valid));
    a_grant_sel     : assert property (@(posedge clk) disable iff (rst) (gnt_valid |-> (grant == sel_onehot(sel))));
`endif

endmodule
